jk_excite_ctrl: RTL

JK_EXCITE_CTRL -- requirements
Module: jk_excite_ctrl

---
 rtl/jk_excite_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/jk_excite_ctrl.sv
// jk_excite_ctrl
//   Drives an external master-slave JK register from a requested next value.
//   A target is accepted from IDLE. For each attempt the block outputs one
//   cycle of J/K excitation derived from the current Q feedback, then holds
//   J=K=0 for one settle cycle, then compares the feedback with the target.
//   A match pulses done. After MAX_TRY failed attempts the block pulses err.
//   After either pulse the block returns to IDLE.
//
// Parameters
//   W        width of the external JK register
//   MAX_TRY  drive attempts allowed before err (1..15)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   tgt_valid  target request valid
//   tgt_ready  high only in IDLE (accepts a target)
//   tgt        requested next Q value (W bits)
//   q_fb       Q feedback from the external JK register (W bits)
//   J, K       registered excitation; nonzero only during DRIVE
//   done       one-cycle pulse when the feedback matched the target
//   err        one-cycle pulse when every attempt failed
module jk_excite_ctrl #(
  parameter int W       = 4,
  parameter int MAX_TRY = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tgt_valid,
  output logic         tgt_ready,
  input  logic [W-1:0] tgt,
  input  logic [W-1:0] q_fb,
  output logic [W-1:0] J,
  output logic [W-1:0] K,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  // Index of the final attempt; the counter never goes past it.
  localparam logic [3:0] TRY_LAST = 4'(MAX_TRY - 1);

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] target;
  logic [3:0]   try_cnt;

  logic         ld_target;
  logic         try_inc;
  logic [W-1:0] drv_target;
  logic [W-1:0] j_nxt;
  logic [W-1:0] k_nxt;

  // Set only the bits that must go 0->1.
  // Don't-care terms are forced to 0, so J and K are never both 1.
  function automatic logic [W-1:0] excite_j(input logic [W-1:0] q,
                                            input logic [W-1:0] t);
    return t & ~q;
  endfunction

  // Reset only the bits that must go 1->0.
  function automatic logic [W-1:0] excite_k(input logic [W-1:0] q,
                                            input logic [W-1:0] t);
    return q & ~t;
  endfunction

  always_comb begin
    state_nxt  = state;
    ld_target  = 1'b0;
    try_inc    = 1'b0;
    drv_target = target;
    case (state)
      IDLE: begin
        if (tgt_valid) begin
          state_nxt  = DRIVE;
          ld_target  = 1'b1;
          // The target register is still loading on this edge.
          // Excite from the incoming request.
          drv_target = tgt;
        end
      end
      DRIVE:  state_nxt = SETTLE;
      SETTLE: state_nxt = CHECK;
      CHECK: begin
        if (q_fb == target) begin
          state_nxt = DONE;
        end else if (try_cnt < TRY_LAST) begin
          state_nxt = DRIVE;
          try_inc   = 1'b1;
        end else begin
          state_nxt = ERR;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    j_nxt = '0;
    k_nxt = '0;
    if (state_nxt == DRIVE) begin
      j_nxt = excite_j(q_fb, drv_target);
      k_nxt = excite_k(q_fb, drv_target);
    end
  end

  assign tgt_ready = (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      target  <= '0;
      try_cnt <= '0;
      J       <= '0;
      K       <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      J     <= j_nxt;
      K     <= k_nxt;
      done  <= (state_nxt == DONE);
      err   <= (state_nxt == ERR);
      if (ld_target) begin
        target  <= tgt;
        try_cnt <= '0;
      end else if (try_inc) begin
        try_cnt <= try_cnt + 4'd1;
      end
    end
  end

endmodule
